// File: rtl/antirrebote_ud_pkg.sv
// rtl/antirrebote_ud_pkg.sv - shared FSM state encoding and counter sizing helper
// Purpose: state type for the per-button debounce FSM and the counter width
//          calculation shared by the channel and the top.
package antirrebote_ud_pkg;

   typedef enum logic [1:0] {
      SUELTO     = 2'd0,
      VALID_P    = 2'd1,
      PRESIONADO = 2'd2,
      VALID_S    = 2'd3
   } estado_t;

   // Width able to hold the largest reload value any state can request.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/antirrebote_ud_canal.sv
// rtl/antirrebote_ud_canal.sv - one button: synchroniser, debounce FSM, auto-repeat
// Purpose: turns one raw asynchronous button into single-cycle raw command pulses.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   i_btn   - raw asynchronous button level
//   o_pulse - combinational one-cycle pulse on accepted press / repeat
module antirrebote_ud_canal
   import antirrebote_ud_pkg::*;
#(
   parameter int DEB_CYCLES = 240000,
   parameter int REP_DELAY  = 6000000,
   parameter int REP_PERIOD = 1200000,
   parameter int ACTIVE_LOW = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int              CW     = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);
   localparam logic [CW-1:0]   C_DEB  = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]   C_DLY  = CW'(REP_DELAY - 1);
   localparam logic [CW-1:0]   C_PER  = (REP_PERIOD == 0) ? '0 : CW'(REP_PERIOD - 1);
   localparam logic            L_IDLE = (ACTIVE_LOW != 0);

   logic [1:0]    r_sync;
   estado_t       r_state;
   estado_t       w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_s;

   // Reset parks the synchroniser at the released level so a held button
   // has to travel the full synchroniser + debounce path again.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {2{L_IDLE}};
      end else begin
         r_sync <= {r_sync[0], i_btn};
      end
   end

   // Normalised level: 1 means pressed regardless of board polarity.
   assign w_s = r_sync[1] ^ L_IDLE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SUELTO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_pulse     = 1'b0;
      case (r_state)
         SUELTO: begin
            if (w_s) begin
               w_state_nxt = VALID_P;
               w_cnt_nxt   = C_DEB;
            end
         end
         VALID_P: begin
            if (!w_s) begin
               w_state_nxt = SUELTO;
            end else if (r_cnt == '0) begin
               w_state_nxt = PRESIONADO;
               o_pulse     = 1'b1;
               w_cnt_nxt   = C_DLY;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         PRESIONADO: begin
            if (!w_s) begin
               w_state_nxt = VALID_S;
               w_cnt_nxt   = C_DEB;
            end else if ((REP_PERIOD != 0) && (r_cnt == '0)) begin
               o_pulse     = 1'b1;
               w_cnt_nxt   = C_PER;
            end else if (r_cnt != '0) begin
               // With auto-repeat disabled the counter parks at zero.
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         VALID_S: begin
            if (w_s) begin
               // Bounce back to pressed: restart the repeat delay, no new pulse.
               w_state_nxt = PRESIONADO;
               w_cnt_nxt   = C_DLY;
            end else if (r_cnt == '0) begin
               w_state_nxt = SUELTO;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = SUELTO;
         end
      endcase
   end

endmodule

// File: rtl/antirrebote_ud.sv
// rtl/antirrebote_ud.sv - two debounced buttons arbitrated into up/down pulses
// Purpose: conditions the raw up/down push-buttons into registered one-cycle
//          command pulses that are never asserted together.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   btn_up   - raw asynchronous button, increment request
//   btn_down - raw asynchronous button, decrement request
//   up       - registered one-cycle increment pulse
//   down     - registered one-cycle decrement pulse
module antirrebote_ud
   import antirrebote_ud_pkg::*;
#(
   parameter int DEB_CYCLES = 240000,
   parameter int REP_DELAY  = 6000000,
   parameter int REP_PERIOD = 1200000,
   parameter int ACTIVE_LOW = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   output logic up,
   output logic down
);

   logic w_pu;
   logic w_pd;
   logic r_up;
   logic r_down;

   antirrebote_ud_canal #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_canal_up (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_up),
      .o_pulse (w_pu)
   );

   antirrebote_ud_canal #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_canal_down (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_down),
      .o_pulse (w_pd)
   );

   // Coincident requests cancel; both channel FSMs keep running undisturbed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_up   <= 1'b0;
         r_down <= 1'b0;
      end else begin
         r_up   <= w_pu & ~w_pd;
         r_down <= w_pd & ~w_pu;
      end
   end

   assign up   = r_up;
   assign down = r_down;

endmodule

// File: tb/tb_antirrebote_ud.sv
// tb/tb_antirrebote_ud.sv - directed self-checking bench for antirrebote_ud
module tb_antirrebote_ud;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic bu, bd, up, down;
   logic nr_bu, nr_bd, nr_up, nr_down;
   logic hi_bu, hi_bd, hi_up, hi_down;

   int n_tests = 0;
   int n_fail  = 0;

   antirrebote_ud #(.DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3), .ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .btn_up(bu), .btn_down(bd), .up(up), .down(down));

   antirrebote_ud #(.DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(0), .ACTIVE_LOW(1)) dut_nr (
      .clk(clk), .reset(reset), .btn_up(nr_bu), .btn_down(nr_bd), .up(nr_up), .down(nr_down));

   antirrebote_ud #(.DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(0), .ACTIVE_LOW(0)) dut_hi (
      .clk(clk), .reset(reset), .btn_up(hi_bu), .btn_down(hi_bd), .up(hi_up), .down(hi_down));

   task automatic chk(input string tag, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Inputs change at negedge; the following posedge is "edge k" and outputs
   // are sampled at the next negedge, i.e. the value held after edge k.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_all();
      bu = 1'b1; bd = 1'b1;
      nr_bu = 1'b1; nr_bd = 1'b1;
      hi_bu = 1'b0; hi_bd = 1'b0;
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      idle_all();
      reset = 1'b1;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_up", up, 1'b0);
      chk("rst_down", down, 1'b0);
      chk("rst_nr_up", nr_up, 1'b0);
      chk("rst_hi_up", hi_up, 1'b0);

      // Press held 8 cycles: single pulse after edge 6, nothing on release
      for (int k = 0; k < 20; k++) begin
         bu = (k < 8) ? 1'b0 : 1'b1;
         step();
         chk($sformatf("press_up@%0d", k), up, k == 6);
         chk($sformatf("press_dn@%0d", k), down, 1'b0);
      end
      do_reset();

      // Glitch of 3 cycles: no pulse
      for (int k = 0; k < 12; k++) begin
         bu = (k < 3) ? 1'b0 : 1'b1;
         step();
         chk($sformatf("glitch_up@%0d", k), up, 1'b0);
      end
      // A clean press afterwards still takes the full latency (FSM back in SUELTO)
      for (int k = 0; k < 10; k++) begin
         bu = 1'b0;
         step();
         chk($sformatf("after_glitch_up@%0d", k), up, k == 6);
      end
      do_reset();

      // Down held 30 cycles: pulses at 6, then every 3 from 16 through 31
      for (int k = 0; k < 45; k++) begin
         bd = (k < 30) ? 1'b0 : 1'b1;
         step();
         chk($sformatf("rep_dn@%0d", k), down,
             (k == 6) || (k >= 16 && k <= 31 && ((k - 16) % 3) == 0));
         chk($sformatf("rep_up@%0d", k), up, 1'b0);
      end
      do_reset();

      // Both pressed 8 cycles: cancel
      for (int k = 0; k < 20; k++) begin
         bu = (k < 8) ? 1'b0 : 1'b1;
         bd = bu;
         step();
         chk($sformatf("both8_up@%0d", k), up, 1'b0);
         chk($sformatf("both8_dn@%0d", k), down, 1'b0);
      end
      do_reset();

      // Both held 20 cycles: repeats cancel too
      for (int k = 0; k < 30; k++) begin
         bu = (k < 20) ? 1'b0 : 1'b1;
         bd = bu;
         step();
         chk($sformatf("both20_up@%0d", k), up, 1'b0);
         chk($sformatf("both20_dn@%0d", k), down, 1'b0);
      end
      do_reset();

      // Reset at edge 4 of a held press: revalidation, pulse after edge 11
      for (int k = 0; k < 16; k++) begin
         bu = 1'b0;
         reset = (k == 4);
         step();
         chk($sformatf("rstmid_up@%0d", k), up, k == 11);
      end
      reset = 1'b0;
      do_reset();

      // Auto-repeat disabled, both polarities: one pulse only
      for (int k = 0; k < 45; k++) begin
         nr_bu = (k < 40) ? 1'b0 : 1'b1;
         hi_bu = (k < 40) ? 1'b1 : 1'b0;
         step();
         chk($sformatf("norep_lo_up@%0d", k), nr_up, k == 6);
         chk($sformatf("norep_hi_up@%0d", k), hi_up, k == 6);
         chk($sformatf("norep_main_up@%0d", k), up, 1'b0);
      end
      chk("norep_lo_dn", nr_down, 1'b0);
      chk("norep_hi_dn", hi_down, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
